// File: rtl/rx_segment_checker.sv
// rx_segment_checker
//   Receive-side sequence checker for the test-frame link. It locks onto one
//   transmitter ID and follows its segment numbering, which wraps to 0 after
//   max_segment. It keeps saturating statistics and flags a link timeout when
//   the locked transmitter goes quiet.
//
// Ports
//   clk125MHz      system clock
//   rst            synchronous active-high reset
//   clear          synchronous clear: counters to 0, back to IDLE (same as rst)
//   max_segment    last segment number before the wrap to 0
//   frame_valid    one-cycle strobe: crc_ok/segment_num/txid/aux are valid
//   crc_ok         FCS result of the strobed frame
//   segment_num    received segment number
//   txid           received transmitter ID
//   aux            received aux byte
//   locked         high while tracking a transmitter
//   locked_txid    transmitter ID captured at lock
//   expected_seg   next segment number expected
//   last_aux       aux byte of the last accepted frame
//   ok_count .. foreign_count   saturating statistics counters (CNT_W bits)
//   seq_error      one-cycle pulse on a gap or a duplicate
//   timeout        sticky until the next lock, rst or clear
module rx_segment_checker #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 125000000
) (
  input  logic             clk125MHz,
  input  logic             rst,
  input  logic             clear,
  input  logic [15:0]      max_segment,
  input  logic             frame_valid,
  input  logic             crc_ok,
  input  logic [15:0]      segment_num,
  input  logic [7:0]       txid,
  input  logic [7:0]       aux,
  output logic             locked,
  output logic [7:0]       locked_txid,
  output logic [15:0]      expected_seg,
  output logic [7:0]       last_aux,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] lost_count,
  output logic [CNT_W-1:0] dup_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] foreign_count,
  output logic             seq_error,
  output logic             timeout
);

  // The idle timer only needs to hold 0 .. TIMEOUT_CYCLES-1.
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  // The lost_count sum must be wide enough for both the counter and the
  // 17-bit gap plus a carry, so the clamp never sees a wrapped value.
  localparam int SUM_W = ((CNT_W > 17) ? CNT_W : 17) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX_EXT = SUM_W'({CNT_W{1'b1}});

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  function automatic logic [15:0] next_seg(input logic [15:0] s, input logic [15:0] max_s);
    if (s == max_s) begin
      return 16'd0;
    end else begin
      return s + 16'd1;
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_locked;
  logic [7:0]       r_locked_txid;
  logic [15:0]      r_expected_seg;
  logic [7:0]       r_last_aux;
  logic [CNT_W-1:0] r_ok_count;
  logic [CNT_W-1:0] r_lost_count;
  logic [CNT_W-1:0] r_dup_count;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_foreign_count;
  logic             r_seq_error;
  logic             r_timeout;
  logic [TMR_W-1:0] r_timer;

  logic [7:0]       w_locked_txid_nxt;
  logic [15:0]      w_expected_seg_nxt;
  logic [7:0]       w_last_aux_nxt;
  logic [CNT_W-1:0] w_ok_nxt;
  logic [CNT_W-1:0] w_lost_nxt;
  logic [CNT_W-1:0] w_dup_nxt;
  logic [CNT_W-1:0] w_err_nxt;
  logic [CNT_W-1:0] w_foreign_nxt;
  logic             w_seq_error_nxt;
  logic             w_timeout_nxt;
  logic [TMR_W-1:0] w_timer_nxt;

  logic             w_good;
  logic             w_foreign;
  logic             w_accept;
  logic             w_match;
  logic             w_dup;
  logic             w_timer_hit;
  logic [15:0]      w_seg_next;
  logic [16:0]      w_wrap_sum;
  logic [16:0]      w_exp17;
  logic [16:0]      w_gap17;
  logic [SUM_W-1:0] w_lost_sum;
  logic [CNT_W-1:0] w_lost_sat;

  assign w_good      = frame_valid & crc_ok;
  assign w_foreign   = (txid != r_locked_txid);
  // In TRACK, a good frame from the locked transmitter re-arms the timer
  // whichever of ok/dup/gap it takes.
  assign w_accept    = w_good & ~w_foreign;
  assign w_seg_next  = next_seg(segment_num, max_segment);
  assign w_match     = (segment_num == r_expected_seg);
  assign w_dup       = (w_seg_next == r_expected_seg);
  assign w_timer_hit = (r_timer == TMR_LAST);

  // segment + max + 1 never exceeds 17 bits, so no carry is lost here.
  assign w_wrap_sum  = {1'b0, segment_num} + {1'b0, max_segment} + 17'd1;
  assign w_exp17     = {1'b0, r_expected_seg};

  // Gap size; the wrapped form goes to 0 when expected_seg lies beyond a
  // reduced max_segment and the difference would be negative.
  always_comb begin
    w_gap17 = 17'd0;
    if (segment_num > r_expected_seg) begin
      w_gap17 = {1'b0, segment_num} - w_exp17;
    end else if (w_wrap_sum < w_exp17) begin
      w_gap17 = 17'd0;
    end else begin
      w_gap17 = w_wrap_sum - w_exp17;
    end
  end

  assign w_lost_sum = SUM_W'(r_lost_count) + SUM_W'(w_gap17);
  assign w_lost_sat = (w_lost_sum > CNT_MAX_EXT) ? {CNT_W{1'b1}} : CNT_W'(w_lost_sum);

  // Next-state logic: lock on the first good frame, drop to IDLE on timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_good) begin
          w_state_nxt = S_TRACK;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_TRACK: begin
        if (w_accept) begin
          w_state_nxt = S_TRACK;
        end else if (w_timer_hit) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_TRACK;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output/datapath next values: frame classification, counters and timer.
  always_comb begin
    w_locked_txid_nxt  = r_locked_txid;
    w_expected_seg_nxt = r_expected_seg;
    w_last_aux_nxt     = r_last_aux;
    w_ok_nxt           = r_ok_count;
    w_lost_nxt         = r_lost_count;
    w_dup_nxt          = r_dup_count;
    w_err_nxt          = r_err_count;
    w_foreign_nxt      = r_foreign_count;
    w_seq_error_nxt    = 1'b0;
    w_timeout_nxt      = r_timeout;
    w_timer_nxt        = r_timer;

    if (frame_valid && !crc_ok) begin
      // A bad FCS only counts; header fields of such a frame are untrusted.
      w_err_nxt = sat_inc(r_err_count);
    end else if (w_good) begin
      case (r_state)
        S_IDLE: begin
          w_locked_txid_nxt  = txid;
          w_expected_seg_nxt = w_seg_next;
          w_last_aux_nxt     = aux;
          w_ok_nxt           = sat_inc(r_ok_count);
        end
        S_TRACK: begin
          if (w_foreign) begin
            w_foreign_nxt = sat_inc(r_foreign_count);
          end else if (w_match) begin
            w_ok_nxt           = sat_inc(r_ok_count);
            w_expected_seg_nxt = w_seg_next;
            w_last_aux_nxt     = aux;
          end else if (w_dup) begin
            w_dup_nxt       = sat_inc(r_dup_count);
            w_seq_error_nxt = 1'b1;
          end else begin
            w_lost_nxt         = w_lost_sat;
            w_ok_nxt           = sat_inc(r_ok_count);
            w_expected_seg_nxt = w_seg_next;
            w_last_aux_nxt     = aux;
            w_seq_error_nxt    = 1'b1;
          end
        end
        default: begin
          w_seq_error_nxt = 1'b0;
        end
      endcase
    end else begin
      w_err_nxt = r_err_count;
    end

    case (r_state)
      S_IDLE: begin
        w_timer_nxt = TMR_W'(0);
        if (w_good) begin
          w_timeout_nxt = 1'b0;
        end else begin
          w_timeout_nxt = r_timeout;
        end
      end
      S_TRACK: begin
        if (w_accept) begin
          w_timer_nxt = TMR_W'(0);
        end else if (w_timer_hit) begin
          w_timer_nxt   = TMR_W'(0);
          w_timeout_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      default: begin
        w_timer_nxt = TMR_W'(0);
      end
    endcase
  end

  // State register; clear behaves exactly like rst and overrides any frame.
  always_ff @(posedge clk125MHz) begin
    if (rst || clear) begin
      r_state  <= S_IDLE;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_locked <= (w_state_nxt == S_TRACK);
    end
  end

  // Registered outputs and idle timer.
  always_ff @(posedge clk125MHz) begin
    if (rst || clear) begin
      r_locked_txid   <= 8'd0;
      r_expected_seg  <= 16'd0;
      r_last_aux      <= 8'd0;
      r_ok_count      <= {CNT_W{1'b0}};
      r_lost_count    <= {CNT_W{1'b0}};
      r_dup_count     <= {CNT_W{1'b0}};
      r_err_count     <= {CNT_W{1'b0}};
      r_foreign_count <= {CNT_W{1'b0}};
      r_seq_error     <= 1'b0;
      r_timeout       <= 1'b0;
      r_timer         <= TMR_W'(0);
    end else begin
      r_locked_txid   <= w_locked_txid_nxt;
      r_expected_seg  <= w_expected_seg_nxt;
      r_last_aux      <= w_last_aux_nxt;
      r_ok_count      <= w_ok_nxt;
      r_lost_count    <= w_lost_nxt;
      r_dup_count     <= w_dup_nxt;
      r_err_count     <= w_err_nxt;
      r_foreign_count <= w_foreign_nxt;
      r_seq_error     <= w_seq_error_nxt;
      r_timeout       <= w_timeout_nxt;
      r_timer         <= w_timer_nxt;
    end
  end

  assign locked        = r_locked;
  assign locked_txid   = r_locked_txid;
  assign expected_seg  = r_expected_seg;
  assign last_aux      = r_last_aux;
  assign ok_count      = r_ok_count;
  assign lost_count    = r_lost_count;
  assign dup_count     = r_dup_count;
  assign err_count     = r_err_count;
  assign foreign_count = r_foreign_count;
  assign seq_error     = r_seq_error;
  assign timeout       = r_timeout;

endmodule
